// File: rtl/ej32_div_arb.sv
// rtl/ej32_div_arb.sv - shared iterative signed divider with two-requester round-robin arbiter
// Java idiv/irem semantics: quotient truncates toward zero, remainder follows the dividend sign.
module ej32_div_arb #(
   parameter int DSZ = 32,
   parameter int CSZ = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic [1:0]     req,
   input  logic [1:0]     op,
   input  logic [DSZ-1:0] x0,
   input  logic [DSZ-1:0] y0,
   input  logic [DSZ-1:0] x1,
   input  logic [DSZ-1:0] y1,
   output logic [1:0]     ack,
   output logic [1:0]     vld,
   output logic [DSZ-1:0] res,
   output logic           dz,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t         state_q, state_d;
   logic           ptr_q, ptr_d;
   logic           gnt_q, gnt_d;
   logic           op_q, op_d;
   logic           sx_q, sx_d;
   logic           sy_q, sy_d;
   logic           dz_q, dz_d;
   logic [CSZ-1:0] cnt_q, cnt_d;
   logic [DSZ-1:0] rem_q, rem_d;
   logic [DSZ-1:0] quo_q, quo_d;
   logic [DSZ-1:0] dvs_q, dvs_d;
   logic [DSZ-1:0] res_q, res_d;

   logic           grant_any;
   logic           g;
   logic [DSZ-1:0] xg, yg, xg_abs, yg_abs;
   logic [DSZ:0]   shifted;
   logic           no_borrow;
   logic [DSZ-1:0] diff;
   logic [DSZ-1:0] q_fix, r_fix;

   always_comb begin
      grant_any = rst_n && (state_q == IDLE) && (req != 2'b00) && !flush;
      case (req)
         2'b01:   g = 1'b0;
         2'b10:   g = 1'b1;
         default: g = ptr_q;
      endcase
      xg     = g ? x1 : x0;
      yg     = g ? y1 : y0;
      xg_abs = xg[DSZ-1] ? -xg : xg;
      yg_abs = yg[DSZ-1] ? -yg : yg;
   end

   // The partial remainder is always below the divisor, so the low DSZ bits of
   // the difference are exact even though the compare needs DSZ+1 bits.
   always_comb begin
      shifted   = {rem_q, quo_q[DSZ-1]};
      no_borrow = (shifted >= {1'b0, dvs_q});
      diff      = shifted[DSZ-1:0] - dvs_q;
      q_fix     = (sx_q ^ sy_q) ? -quo_q : quo_q;
      r_fix     = sx_q ? -rem_q : rem_q;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      op_d    = op_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      dz_d    = dz_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               ptr_d = ~g;
               gnt_d = g;
               op_d  = op[g];
               sx_d  = xg[DSZ-1];
               sy_d  = yg[DSZ-1];
               dvs_d = yg_abs;
               quo_d = xg_abs;
               rem_d = '0;
               cnt_d = '0;
               dz_d  = (yg == '0);
               if (yg == '0) begin
                  res_d   = '0;
                  state_d = DONE;
               end else begin
                  state_d = ITER;
               end
            end
         end
         ITER: begin
            rem_d = no_borrow ? diff : shifted[DSZ-1:0];
            quo_d = {quo_q[DSZ-2:0], no_borrow};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CSZ'(DSZ - 1))
               state_d = FIX;
         end
         FIX: begin
            // An aborted operation must not disturb the last delivered result.
            if (!flush)
               res_d = op_q ? r_fix : q_fix;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (flush)
         state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         gnt_q   <= 1'b0;
         op_q    <= 1'b0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         dz_q    <= 1'b0;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         op_q    <= op_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         dz_q    <= dz_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      ack  = grant_any ? (g ? 2'b10 : 2'b01) : 2'b00;
      vld  = ((state_q == DONE) && !flush) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
      res  = res_q;
      dz   = dz_q;
      busy = (state_q != IDLE);
   end

endmodule

// File: tb/tb_ej32_div_arb.sv
// tb/tb_ej32_div_arb.sv - self-checking bench for ej32_div_arb
// Directed vector table, random operations against a 64-bit arithmetic model, and sequence corners.
module tb_ej32_div_arb;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [1:0]  req;
   logic [1:0]  op;
   logic [31:0] x0, y0, x1, y1;
   logic [1:0]  ack, vld;
   logic [31:0] res;
   logic        dz;
   logic        busy;

   int n_total = 0;
   int n_pass  = 0;

   ej32_div_arb #(.DSZ(32), .CSZ(6)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .op(op),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .ack(ack), .vld(vld), .res(res), .dz(dz), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          rq;
      bit          opb;
      logic [31:0] xv;
      logic [31:0] yv;
      logic [31:0] er;
      bit          edz;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   // Java semantics from 64-bit signed arithmetic, where MIN/-1 cannot overflow.
   function automatic logic [31:0] ref_res(input bit opb, input logic [31:0] xv, input logic [31:0] yv);
      longint xs, ys, r;
      xs = longint'($signed(xv));
      ys = longint'($signed(yv));
      if (ys == 0) return 32'd0;
      r = opb ? (xs % ys) : (xs / ys);
      return r[31:0];
   endfunction

   // Caller is at a negedge with the divider idle.
   task automatic do_op(input string nm, input int rq, input bit opb,
                        input logic [31:0] xv, input logic [31:0] yv,
                        input logic [31:0] er, input bit edz);
      int lat;
      op[rq] = opb;
      if (rq == 0) begin x0 = xv; y0 = yv; end
      else begin x1 = xv; y1 = yv; end
      req = (rq == 0) ? 2'b01 : 2'b10;
      #1;
      chk({nm, ":ack"}, 32'(ack), (rq == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      req = 2'b00;
      if (rq == 0) begin x0 = $urandom; y0 = $urandom; end
      else begin x1 = $urandom; y1 = $urandom; end
      #1;
      chk({nm, ":busy1"}, 32'(busy), 32'd1);
      lat = 1;
      while (vld == 2'b00 && lat < 60) begin
         @(negedge clk);
         #1;
         lat++;
      end
      chk({nm, ":latency"}, 32'(lat), edz ? 32'd1 : 32'd34);
      chk({nm, ":vld"}, 32'(vld), (rq == 0) ? 32'd1 : 32'd2);
      chk({nm, ":res"}, res, er);
      chk({nm, ":dz"}, 32'(dz), 32'(edz));
      @(negedge clk);
      #1;
      chk({nm, ":idle"}, 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 2'b00;
      flush = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 80) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({nm, ":drain"}, 32'(busy), 32'd0);
   endtask

   always @(negedge clk) begin
      #2;
      n_total++;
      if ($onehot0(ack) && $onehot0(vld) && (rst_n || vld == 2'b00)) n_pass++;
      else $display("FAIL protocol ack=%b vld=%b rst_n=%b required one-hot-or-zero, no vld in reset",
                    ack, vld, rst_n);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          ack_cyc[4];
      logic [1:0]  ack_val[4];
      int          nack;
      bit          novld;
      int          rq;
      bit          opb;
      logic [31:0] xv, yv;
      int          lat;

      vecs[0]  = '{0, 1'b0, 32'd7,        32'd2,        32'd3,        1'b0};
      vecs[1]  = '{1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
      vecs[2]  = '{1, 1'b0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
      vecs[4]  = '{1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
      vecs[5]  = '{0, 1'b0, 32'd5,        32'd0,        32'd0,        1'b1};
      vecs[6]  = '{0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0};
      vecs[7]  = '{0, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        1'b0};
      vecs[8]  = '{1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0};
      vecs[9]  = '{0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0};
      vecs[10] = '{1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
      vecs[11] = '{0, 1'b1, 32'h80000000, 32'd3,        32'hFFFFFFFE, 1'b0};
      vecs[12] = '{1, 1'b0, 32'd0,        32'd5,        32'd0,        1'b0};
      vecs[13] = '{0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1,        1'b0};

      op = 2'b00; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
      do_reset();
      #1;
      chk("reset_outputs", {25'd0, ack, vld, dz, busy}, 32'd0);
      chk("reset_res", res, 32'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         do_op($sformatf("vec%0d", i), vecs[i].rq, vecs[i].opb, vecs[i].xv, vecs[i].yv,
               vecs[i].er, vecs[i].edz);
      end

      for (int i = 0; i < 40; i++) begin
         rq  = int'($urandom_range(0, 1));
         opb = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0:       xv = 32'h80000000;
            1, 2:    xv = 32'($urandom_range(0, 100)) - 32'd50;
            default: xv = $urandom;
         endcase
         case ($urandom_range(0, 9))
            0:          yv = 32'd0;
            1:          yv = 32'hFFFFFFFF;
            2:          yv = 32'd1;
            3, 4, 5:    yv = 32'($urandom_range(0, 40)) - 32'd20;
            default:    yv = $urandom;
         endcase
         @(negedge clk);
         do_op($sformatf("rand%0d", i), rq, opb, xv, yv, ref_res(opb, xv, yv), (yv == 32'd0));
      end

      // Fairness: both requesters held from reset.
      @(negedge clk);
      do_reset();
      x0 = 32'd100; y0 = 32'd7; x1 = -32'd100; y1 = 32'd7; op = 2'b00;
      req = 2'b11;
      nack = 0;
      for (int i = 0; i < 4; i++) begin ack_cyc[i] = -1; ack_val[i] = 2'b00; end
      for (int i = 0; i < 110; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (ack != 2'b00 && nack < 4) begin
            ack_cyc[nack] = i;
            ack_val[nack] = ack;
            nack++;
         end
         if (vld == 2'b01) chk("fair_res0", res, 32'd14);
         if (vld == 2'b10) chk("fair_res1", res, 32'hFFFFFFF2);
      end
      req = 2'b00;
      chk("fair_ack0_cyc", 32'(ack_cyc[0]), 32'd0);
      chk("fair_ack0_val", 32'(ack_val[0]), 32'd1);
      chk("fair_ack1_cyc", 32'(ack_cyc[1]), 32'd35);
      chk("fair_ack1_val", 32'(ack_val[1]), 32'd2);
      chk("fair_ack2_cyc", 32'(ack_cyc[2]), 32'd70);
      chk("fair_ack2_val", 32'(ack_val[2]), 32'd1);
      wait_idle("fair");

      // Abort by flush at cycle 10.
      @(negedge clk);
      x0 = 32'd1000; y0 = 32'd3; op = 2'b00; req = 2'b01;
      #1;
      chk("abort_ack", 32'(ack), 32'd1);
      novld = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         req = 2'b00;
         if (i == 10) flush = 1'b1;
         #1;
         if (vld != 2'b00) novld = 1'b0;
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      if (vld != 2'b00) novld = 1'b0;
      chk("abort_busy11", 32'(busy), 32'd0);
      chk("abort_novld", 32'(novld), 32'd1);
      do_op("abort_next", 1, 1'b0, 32'd1000, 32'hFFFFFFFD, 32'hFFFFFEB3, 1'b0);

      // Asynchronous reset at cycle 20 of an operation granted to requester 0.
      @(negedge clk);
      x0 = 32'd1000; y0 = 32'd7; op = 2'b00; req = 2'b01;
      #1;
      chk("rstmid_ack", 32'(ack), 32'd1);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         req = 2'b00;
      end
      rst_n = 1'b0;
      #1;
      chk("rstmid_outputs", {25'd0, ack, vld, dz, busy}, 32'd0);
      chk("rstmid_res", res, 32'd0);
      req = 2'b11;
      #1;
      chk("rstmid_ack_blocked", 32'(ack), 32'd0);
      req = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      novld = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (vld != 2'b00) novld = 1'b0;
      end
      chk("rstmid_novld", 32'(novld), 32'd1);
      x0 = 32'd9; y0 = 32'd3; x1 = 32'd8; y1 = 32'd2; op = 2'b00; req = 2'b11;
      #1;
      chk("rstmid_ptr", 32'(ack), 32'd1);
      @(negedge clk);
      req = 2'b00;
      #1;
      lat = 1;
      while (vld == 2'b00 && lat < 60) begin
         @(negedge clk);
         #1;
         lat++;
      end
      chk("rstmid_lat", 32'(lat), 32'd34);
      chk("rstmid_vld", 32'(vld), 32'd1);
      chk("rstmid_result", res, 32'd3);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
